// File: rtl/ndn_router_pkg.sv
// Shared types for the multi-face NDN router: event codes, FSM states and packet-type encoding.
package ndn_router_pkg;

  typedef enum logic [2:0] {
    EVT_FORWARD     = 3'd0,
    EVT_AGGREGATE   = 3'd1,
    EVT_DUPLICATE   = 3'd2,
    EVT_TABLE_FULL  = 3'd3,
    EVT_NO_ROUTE    = 3'd4,
    EVT_DATA_HIT    = 3'd5,
    EVT_UNSOLICITED = 3'd6
  } evt_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_UPDATE,
    ST_EMIT
  } state_e;

  localparam logic PKT_INTEREST = 1'b1;
  localparam logic PKT_DATA     = 1'b0;

endpackage

// File: rtl/ndn_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping; the pointer lives in the parent.
module ndn_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  int   w_j;
  logic w_found;

  // NOTE: every output gets a default before the loop, so no path leaves a value held and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_j       = 0;
    for (int i = 0; i < N; i++) begin
      w_j = int'(ptr) + i;
      if (w_j >= N) w_j = w_j - N;
      if (!w_found && req[w_j]) begin
        w_found      = 1'b1;
        grant[w_j]   = 1'b1;
        grant_idx    = PW'(w_j);
      end
    end
  end

endmodule

// File: rtl/ndn_face_router.sv
// Multi-face NDN router core: round-robin face arbitration into a shared linear-search PIT.
// Optional macro PIT_LIFETIME_EN adds per-entry lifetime counters; the default build has none.
module ndn_face_router
  import ndn_router_pkg::*;
#(
  parameter int                   NUM_FACES = 4,
  parameter int                   PREFIX_W  = 64,
  parameter int                   PIT_DEPTH = 8,
  parameter logic [NUM_FACES-1:0] FWD_MASK  = {{(NUM_FACES-1){1'b0}}, 1'b1},
  parameter int                   LIFETIME  = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_FACES-1:0]            in_valid,
  output logic [NUM_FACES-1:0]            in_ready,
  input  logic [NUM_FACES-1:0]            in_is_interest,
  input  logic [NUM_FACES*PREFIX_W-1:0]   in_prefix,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_is_interest,
  output logic [PREFIX_W-1:0]             out_prefix,
  output logic [NUM_FACES-1:0]            out_faces,
  output logic                            evt_valid,
  output logic [2:0]                      evt_code,
  output logic [$clog2(PIT_DEPTH+1)-1:0]  pit_count
);

  localparam int FW = $clog2(NUM_FACES);
  localparam int IW = $clog2(PIT_DEPTH);
  localparam int CW = $clog2(PIT_DEPTH+1);

  state_e                r_state, w_state_next;
  logic [FW-1:0]         r_rr_ptr, r_face, w_grant_idx;
  logic [NUM_FACES-1:0]  w_grant;
  logic                  r_is_interest;
  logic [PREFIX_W-1:0]   r_prefix;
  logic [IW-1:0]         r_idx, r_hit_idx, r_free_idx;
  logic                  r_hit, r_free;
  logic                  w_accept, w_upd, w_search_done;

  logic [PIT_DEPTH-1:0]  r_valid, w_valid_next, w_expire;
  logic [CW-1:0]         r_pit_count, w_count_next;
  logic [PREFIX_W-1:0]   r_pit_prefix [PIT_DEPTH];
  logic [NUM_FACES-1:0]  r_pit_faces  [PIT_DEPTH];

  evt_code_e             w_code;
  logic                  w_emit, w_insert, w_merge, w_remove, w_hit_live;
  logic [NUM_FACES-1:0]  w_face_bit, w_hit_faces, w_fwd, w_dst;

  logic                  r_out_is_interest;
  logic [PREFIX_W-1:0]   r_out_prefix;
  logic [NUM_FACES-1:0]  r_out_faces;

  ndn_rr_arbiter #(.N(NUM_FACES), .PW(FW)) u_arb (
    .req       (in_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_accept      = (r_state == ST_IDLE) && (|in_valid);
  assign w_upd         = (r_state == ST_UPDATE);
  assign w_search_done = (r_idx == IW'(PIT_DEPTH-1));

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (|in_valid)     w_state_next = ST_SEARCH;
      ST_SEARCH: if (w_search_done) w_state_next = ST_UPDATE;
      ST_UPDATE: w_state_next = w_emit ? ST_EMIT : ST_IDLE;
      ST_EMIT:   if (out_ready)     w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready        = (r_state == ST_IDLE) ? w_grant : '0;
    evt_valid       = w_upd;
    evt_code        = w_upd ? w_code : 3'd0;
    out_valid       = (r_state == ST_EMIT);
    out_is_interest = r_out_is_interest;
    out_prefix      = r_out_prefix;
    out_faces       = r_out_faces;
    pit_count       = r_pit_count;
  end

  // The hit is re-validated here: with lifetimes enabled it may have expired after being compared.
  always_comb begin
    w_face_bit  = NUM_FACES'(1) << r_face;
    w_hit_live  = r_hit && r_valid[r_hit_idx];
    w_hit_faces = r_pit_faces[r_hit_idx];
    w_fwd       = FWD_MASK & ~w_face_bit;
    w_code      = EVT_UNSOLICITED;
    w_emit      = 1'b0;
    w_insert    = 1'b0;
    w_merge     = 1'b0;
    w_remove    = 1'b0;
    w_dst       = '0;
    if (r_is_interest == PKT_INTEREST) begin
      if (w_hit_live) begin
        if ((w_hit_faces & w_face_bit) != '0) begin
          w_code = EVT_DUPLICATE;
        end else begin
          w_code  = EVT_AGGREGATE;
          w_merge = 1'b1;
        end
      end else if (w_fwd == '0) begin
        w_code = EVT_NO_ROUTE;
      end else if (!r_free) begin
        w_code = EVT_TABLE_FULL;
      end else begin
        w_code   = EVT_FORWARD;
        w_insert = 1'b1;
        w_emit   = 1'b1;
        w_dst    = w_fwd;
      end
    end else if (w_hit_live) begin
      w_code   = EVT_DATA_HIT;
      w_remove = 1'b1;
      w_dst    = w_hit_faces & ~w_face_bit;
      w_emit   = (w_dst != '0);
    end
  end

  // An UPDATE write to an entry overrides a same-cycle expiry of that entry.
  always_comb begin
    w_valid_next = r_valid & ~w_expire;
    if (w_upd && w_insert) w_valid_next[r_free_idx] = 1'b1;
    if (w_upd && w_merge)  w_valid_next[r_hit_idx]  = 1'b1;
    if (w_upd && w_remove) w_valid_next[r_hit_idx]  = 1'b0;
    w_count_next = '0;
    for (int i = 0; i < PIT_DEPTH; i++) w_count_next = w_count_next + CW'(w_valid_next[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr          <= '0;
      r_face            <= '0;
      r_is_interest     <= PKT_DATA;
      r_prefix          <= '0;
      r_idx             <= '0;
      r_hit             <= 1'b0;
      r_hit_idx         <= '0;
      r_free            <= 1'b0;
      r_free_idx        <= '0;
      r_valid           <= '0;
      r_pit_count       <= '0;
      r_out_is_interest <= 1'b0;
      r_out_prefix      <= '0;
      r_out_faces       <= '0;
    end else begin
      if (w_accept) begin
        r_rr_ptr      <= (w_grant_idx == FW'(NUM_FACES-1)) ? '0 : w_grant_idx + 1'b1;
        r_face        <= w_grant_idx;
        r_is_interest <= in_is_interest[w_grant_idx];
        r_prefix      <= in_prefix[w_grant_idx*PREFIX_W +: PREFIX_W];
        r_idx         <= '0;
        r_hit         <= 1'b0;
        r_free        <= 1'b0;
      end
      if (r_state == ST_SEARCH) begin
        r_idx <= r_idx + 1'b1;
        if (r_valid[r_idx] && (r_pit_prefix[r_idx] == r_prefix)) begin
          r_hit     <= 1'b1;
          r_hit_idx <= r_idx;
        end
        if (!r_valid[r_idx] && !r_free) begin
          r_free     <= 1'b1;
          r_free_idx <= r_idx;
        end
      end
      if (w_upd && w_emit) begin
        r_out_is_interest <= r_is_interest;
        r_out_prefix      <= r_prefix;
        r_out_faces       <= w_dst;
      end
      r_valid     <= w_valid_next;
      r_pit_count <= w_count_next;
    end
  end

  // NOTE: table contents are not reset; r_valid alone decides whether an entry exists.
  always_ff @(posedge clk) begin
    if (w_upd && w_insert) begin
      r_pit_prefix[r_free_idx] <= r_prefix;
      r_pit_faces[r_free_idx]  <= w_face_bit;
    end
    if (w_upd && w_merge) r_pit_faces[r_hit_idx] <= w_hit_faces | w_face_bit;
  end

`ifdef PIT_LIFETIME_EN
  localparam int TW = (LIFETIME > 2) ? $clog2(LIFETIME) : 1;
  logic [TW-1:0] r_ttl [PIT_DEPTH];

  // An entry drops on the same edge its counter reaches zero.
  always_comb begin
    w_expire = '0;
    for (int i = 0; i < PIT_DEPTH; i++) w_expire[i] = r_valid[i] && (r_ttl[i] == TW'(1));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PIT_DEPTH; i++) begin
      if (w_upd && ((w_insert && (r_free_idx == IW'(i))) || (w_merge && (r_hit_idx == IW'(i)))))
        r_ttl[i] <= TW'(LIFETIME-1);
      else if (r_ttl[i] != '0)
        r_ttl[i] <= r_ttl[i] - 1'b1;
    end
  end
`else
  assign w_expire = '0;
`endif

endmodule

// File: tb/tb_ndn_face_router.sv
// Self-checking bench for ndn_face_router: directed test-plan cases plus randomized traffic against a queue/array PIT model.
module tb_ndn_face_router;
  import ndn_router_pkg::*;

  localparam int             NF = 4;
  localparam int             PW = 64;
  localparam int             PD = 8;
  localparam logic [NF-1:0]  FM = 4'b0001;
  localparam int             LT = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NF-1:0]      in_valid = '0;
  logic [NF-1:0]      in_ready;
  logic [NF-1:0]      in_is_interest = '0;
  logic [NF*PW-1:0]   in_prefix = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_is_interest;
  logic [PW-1:0]      out_prefix;
  logic [NF-1:0]      out_faces;
  logic               evt_valid;
  logic [2:0]         evt_code;
  logic [$clog2(PD+1)-1:0] pit_count;

  ndn_face_router #(
    .NUM_FACES(NF), .PREFIX_W(PW), .PIT_DEPTH(PD), .FWD_MASK(FM), .LIFETIME(LT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_interest(in_is_interest), .in_prefix(in_prefix),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_interest(out_is_interest),
    .out_prefix(out_prefix), .out_faces(out_faces),
    .evt_valid(evt_valid), .evt_code(evt_code), .pit_count(pit_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference PIT: prefix -> set of requesting faces.
  logic [NF-1:0] pit [logic [63:0]];

  function automatic void predict(input int f, input bit is_int, input logic [63:0] p,
                                  output evt_code_e code, output logic [NF-1:0] faces);
    logic [NF-1:0] fb;
    logic [NF-1:0] fwd;
    fb    = '0;
    fb[f] = 1'b1;
    faces = '0;
    if (is_int) begin
      if (pit.exists(p)) begin
        if ((pit[p] & fb) != '0) code = EVT_DUPLICATE;
        else begin
          pit[p] = pit[p] | fb;
          code   = EVT_AGGREGATE;
        end
      end else begin
        fwd = FM & ~fb;
        if (fwd == '0)           code = EVT_NO_ROUTE;
        else if (pit.num() >= PD) code = EVT_TABLE_FULL;
        else begin
          pit[p] = fb;
          code   = EVT_FORWARD;
          faces  = fwd;
        end
      end
    end else if (pit.exists(p)) begin
      faces = pit[p] & ~fb;
      pit.delete(p);
      code  = EVT_DATA_HIT;
    end else begin
      code = EVT_UNSOLICITED;
    end
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pit.delete();
  endtask

  // One descriptor end to end; stall > 0 holds out_ready low for stall+1 EMIT cycles.
  task automatic do_txn(input int f, input bit is_int, input logic [63:0] p, input int stall);
    evt_code_e     code;
    logic [NF-1:0] faces;
    int            cyc;
    @(negedge clk);
    out_ready              = (stall == 0);
    in_valid               = '0;
    in_valid[f]            = 1'b1;
    in_is_interest[f]      = is_int;
    in_prefix[f*PW +: PW]  = p;
    #1;
    cyc = 0;
    while (!in_ready[f] && cyc < 50) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (!in_ready[f]) begin
      check("grant_timeout", 64'(in_ready[f]), 64'd1);
      in_valid  = '0;
      out_ready = 1'b1;
      return;
    end
    predict(f, is_int, p, code, faces);
    @(negedge clk);
    in_valid = '0;
    cyc = 1;
    while (!evt_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("evt_cycle", 64'(cyc), 64'(PD+1));
    check("evt_code", 64'(evt_code), 64'(code));
    @(negedge clk);
    check("evt_one_shot", 64'(evt_valid), 64'd0);
    check("pit_count", 64'(pit_count), 64'(pit.num()));
    check("out_valid", 64'(out_valid), 64'(faces != '0));
    if (faces != '0) begin
      check("out_faces", 64'(out_faces), 64'(faces));
      check("out_is_interest", 64'(out_is_interest), 64'(is_int));
      check("out_prefix", out_prefix, p);
      if (stall > 0) begin
        in_valid = '1;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk); #1;
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_faces", 64'(out_faces), 64'(faces));
          check("stall_prefix", out_prefix, p);
          check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = '0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      check("out_drop", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            rr_exp;
    int            idx;
    int            w;
    int            k;
    bit            seen_evt, seen_out;
    logic [63:0]   pool [12];

    reset_dut();
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_evt_valid", 64'(evt_valid), 64'd0);
    check("rst_pit_count", 64'(pit_count), 64'd0);
    check("rst_out_faces", 64'(out_faces), 64'd0);

`ifndef PIT_LIFETIME_EN
    do_txn(2, 1'b1, 64'hA5A5_0000_0000_0001, 0);
    do_txn(3, 1'b1, 64'hA5A5_0000_0000_0001, 0);
    do_txn(3, 1'b1, 64'hA5A5_0000_0000_0001, 0);
    do_txn(0, 1'b0, 64'hA5A5_0000_0000_0001, 4);
    for (int i = 0; i < PD + 1; i++) do_txn(1, 1'b1, 64'h1000 + 64'(i), 0);
    do_txn(0, 1'b1, 64'h2000, 0);
    do_txn(2, 1'b0, 64'h3000, 0);
`endif

    // All faces request continuously from reset; grants must rotate.
    in_valid       = '1;
    in_is_interest = '0;
    for (int f = 0; f < NF; f++) in_prefix[f*PW +: PW] = 64'hDEAD_BEEF_0000_0000 | 64'(f);
    reset_dut();
    rr_exp = 0;
    for (int g = 0; g < 5; g++) begin
      #1;
      w = 0;
      while (in_ready == '0 && w < 40) begin
        @(negedge clk); #1;
        w++;
      end
      check("grant_onehot", 64'($onehot(in_ready)), 64'd1);
      idx = -1;
      for (int f = NF - 1; f >= 0; f--) if (in_ready[f]) idx = f;
      check("grant_order", 64'(idx), 64'(rr_exp));
      rr_exp = (rr_exp + 1) % NF;
      @(negedge clk);
    end
    in_valid = '0;

    // Reset while the descriptor is being searched: it must vanish without trace.
    reset_dut();
    in_valid[2]              = 1'b1;
    in_is_interest[2]        = 1'b1;
    in_prefix[2*PW +: PW]    = 64'hBEEF_0000_0000_0002;
    #1;
    check("rst_search_grant", 64'(in_ready[2]), 64'd1);
    @(negedge clk);
    in_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pit.delete();
    seen_evt = 1'b0;
    seen_out = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      seen_evt |= evt_valid;
      seen_out |= out_valid;
    end
    check("rst_search_evt", 64'(seen_evt), 64'd0);
    check("rst_search_out", 64'(seen_out), 64'd0);
    check("rst_search_count", 64'(pit_count), 64'd0);

`ifndef PIT_LIFETIME_EN
    for (int i = 0; i < 12; i++) pool[i] = {32'hC0DE_0000 | 32'(i), $urandom()};
    for (int t = 0; t < 80; t++) begin
      do_txn(int'($urandom_range(0, NF - 1)),
             ($urandom_range(0, 99) < 65),
             pool[$urandom_range(0, 11)],
             ($urandom_range(0, 7) == 0) ? 2 : 0);
    end
`else
    reset_dut();
    do_txn(2, 1'b1, 64'hA5A5_0000_0000_0001, 0);
    k = 2;
    while (pit_count != '0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("ttl_expire_cycle", 64'(k), 64'(LT));
    pit.delete(64'hA5A5_0000_0000_0001);
    do_txn(0, 1'b0, 64'hA5A5_0000_0000_0001, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
